baud_gen_frac: RTL and testbench

Fractional-N baud tick generator, successor to the fixed integer-divide generator used by the UART links of the coincidence-counting unit. A phase accumulator produces an oversample tick (`os_tick`) and a bit tick (`baud_tick`, every OVERSAMPLE oversample ticks) with sub-cycle average accuracy at any baud rate. It also supports runtime rate changes through a valid/ready handshake and phase realignment for receiver start-bit centring. One instance feeds a UART TX/RX pair.

---
 rtl/baud_pkg.sv | 21 ++
 rtl/baud_phase_acc.sv | 36 +++
 rtl/baud_gen_frac.sv | 122 ++++++++++++
 tb/tb_baud_gen_frac.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared constants and helpers for the fractional baud generator.
package baud_pkg;

  localparam int ACC_W_DEFAULT = 32;

  // round(baud * os * 2^acc_w / clk_hz); 128-bit intermediate covers acc_w up to 48
  function automatic logic [63:0] calc_inc(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned os,
                                           input int unsigned     acc_w);
    logic [127:0] num;
    num = (128'(baud) * 128'(os)) << acc_w;
    num = num + 128'(clk_hz / 64'd2);
    return 64'(num / 128'(clk_hz));
  endfunction

  function automatic bit os_legal(input int os);
    return (os >= 4) && (os <= 64) && ((os & (os - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// rtl/baud_phase_acc.sv - phase accumulator with registered carry-out.
module baud_phase_acc
  import baud_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (!en || clr) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_carry <= w_sum[ACC_W];
    end
  end

  assign carry = r_carry;

endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-N oversample/bit tick generator with sync realign.
// Runtime increment handshake present only when BAUD_GEN_RUNTIME_CFG_EN is defined.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 19200,
  parameter int OVERSAMPLE  = 16,
  parameter int ACC_W       = ACC_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          sync,
  input  logic                          cfg_valid,
  input  logic [ACC_W-1:0]              cfg_inc,
  output logic                          cfg_ready,
  output logic                          os_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int               OS_W        = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST     = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF     = OS_W'(OVERSAMPLE / 2);
  localparam logic [ACC_W-1:0] INC_DEFAULT =
    ACC_W'(calc_inc(64'(CLK_FREQ_HZ), 64'(BAUD_RATE), 64'(OVERSAMPLE), ACC_W));

  if (!os_legal(OVERSAMPLE) || (ACC_W < 16) || (ACC_W > 48)) begin : g_bad_cfg
    $error("baud_gen_frac: illegal OVERSAMPLE or ACC_W");
  end

  logic [ACC_W-1:0] w_inc;
  logic             w_carry;
  logic             w_sync;
  logic             w_baud_evt;
  logic [OS_W-1:0]  r_os_cnt;
  logic             r_os_tick;
  logic             r_baud_tick;

  assign w_sync     = sync && en;
  assign w_baud_evt = w_carry && (r_os_cnt == OS_LAST);

  baud_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (w_sync),
    .inc   (w_inc),
    .carry (w_carry)
  );

  // Sync outranks a coincident carry: the tick is dropped and the bit restarts mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (!en) begin
      r_os_cnt    <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (w_sync) begin
      r_os_cnt    <= OS_HALF;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else begin
      r_os_tick   <= w_carry;
      r_baud_tick <= w_baud_evt;
      if (w_carry) begin
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end
    end
  end

`ifdef BAUD_GEN_RUNTIME_CFG_EN
  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_pend_inc;
  logic             r_pend;
  logic             r_cfg_ready;
  logic             w_xfer;
  logic             w_apply;

  assign w_xfer  = cfg_valid && r_cfg_ready;
  // New rate lands only on a bit boundary so no bit is ever split between rates.
  assign w_apply = r_pend && (!en || (w_baud_evt && !w_sync));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc       <= INC_DEFAULT;
      r_pend_inc  <= '0;
      r_pend      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else if (w_xfer) begin
      r_pend_inc  <= cfg_inc;
      r_pend      <= 1'b1;
      r_cfg_ready <= 1'b0;
    end else if (w_apply) begin
      r_inc  <= r_pend_inc;
      r_pend <= 1'b0;
    end else if (!r_pend && !r_cfg_ready) begin
      r_cfg_ready <= 1'b1;
    end
  end

  assign w_inc     = r_inc;
  assign cfg_ready = r_cfg_ready;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = cfg_valid ^ (^cfg_inc);
  assign w_inc        = INC_DEFAULT;
  assign cfg_ready    = 1'b0;
`endif

  assign os_tick   = r_os_tick;
  assign baud_tick = r_baud_tick;
  assign os_phase  = r_os_cnt;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - directed self-checking bench for baud_gen_frac.
`timescale 1ns/1ps
module tb_baud_gen_frac;

  localparam longint INC_DEF = 64'd13194140;
`ifdef BAUD_GEN_RUNTIME_CFG_EN
  localparam longint READY_RST = 1;
`else
  localparam longint READY_RST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_inc = '0;
  logic        cfg_ready;
  logic        os_tick;
  logic        baud_tick;
  logic [3:0]  os_phase;

  int n_checks = 0;
  int n_fail   = 0;
  int n, k, span;
  longint c8;

  always #5 clk = ~clk;

  baud_gen_frac #(
    .CLK_FREQ_HZ (100_000_000),
    .BAUD_RATE   (19200),
    .OVERSAMPLE  (16),
    .ACC_W       (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_inc   (cfg_inc),
    .cfg_ready (cfg_ready),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .os_phase  (os_phase)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint d;
    n_checks++;
    d = (got > exp) ? got - exp : exp - got;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_os(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!os_tick && cnt < max);
  endtask

  task automatic wait_baud(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!baud_tick && cnt < max);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_os_tick", os_tick, 0);
    check("rst_baud_tick", baud_tick, 0);
    check("rst_os_phase", os_phase, 0);
    check("rst_cfg_ready", cfg_ready, READY_RST);
    rst_n = 1'b1;
    tick();

    // acc reaches 2^32 after ceil(2^32/inc)=326 adds, tick one edge later
    en = 1'b1;
    wait_os(400, n);
    check("en_to_first_os", n, 327);
    check("first_os_phase", os_phase, 1);
    check("first_no_baud", baud_tick, 0);

`ifndef BAUD_GEN_RUNTIME_CFG_EN
    cfg_valid = 1'b1;
    cfg_inc   = 32'h8000_0000;
`endif
    // 2^32/inc = 325.52 cycles per oversample tick
    for (int i = 0; i < 6; i++) begin
      wait_os(400, n);
      check("os_period_x2", 2 * n, 651, 1);
    end
    wait_baud(6000, n);
    check("baud_os_coincide", os_tick, 1);
    check("baud_phase_zero", os_phase, 0);
    span = 0;
    for (int i = 0; i < 4; i++) begin
      wait_baud(6000, n);
      check("bit_period", n, 5208, 1);
      span += n;
    end
    check("span_4_bits", span, 20833, 1);
    check("cfg_ready_level", cfg_ready, READY_RST);
    cfg_valid = 1'b0;

    // sync mid-bit, well away from any carry
    repeat (100) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    check("sync_no_tick", os_tick, 0);
    check("sync_phase", os_phase, 8);
    wait_os(400, n);
    check("sync_first_os", n, 327);
    check("sync_first_phase", os_phase, 9);
    k = 0;
    do begin
      wait_os(400, n);
      k++;
    end while (!baud_tick && k < 10);
    check("sync_os_to_baud", k, 7);

    // sync landing on the carry of a baud event: kth carry at ceil(k*2^32/inc) after clear
    sync = 1'b1; tick(); sync = 1'b0;
    c8 = (64'd8 * 64'd4294967296 + INC_DEF - 1) / INC_DEF;
    check("sync_carry_edge", c8, 2605);
    repeat (int'(c8)) tick();
    check("pre_sync_phase", os_phase, 15);
    sync = 1'b1; tick(); sync = 1'b0;
    check("sync_on_baud_os", os_tick, 0);
    check("sync_on_baud_bt", baud_tick, 0);
    check("sync_on_baud_phase", os_phase, 8);
    wait_os(400, n);
    check("resync_first_os", n, 327);

`ifdef BAUD_GEN_RUNTIME_CFG_EN
    wait_baud(6000, n);
    cfg_valid = 1'b1; cfg_inc = 32'h8000_0000; tick(); cfg_valid = 1'b0;
    check("xfer_ready_drop", cfg_ready, 0);
    wait_baud(6000, n);
    check("apply_ready_low", cfg_ready, 0);
    tick();
    check("apply_ready_back", cfg_ready, 1);
    // residual acc < 2^31 after the switch: first carry two edges in, so the bit is 33, not short
    wait_baud(64, n);
    check("switch_bit_len", n + 1, 33);
    wait_os(8, n);
    check("os_period_fast", n, 2);
    wait_baud(64, n);
    check("baud_period_fast", n + 2, 32);

    repeat (6) tick();
    sync = 1'b1; tick(); sync = 1'b0;
    check("fast_sync_no_tick", os_tick, 0);
    check("fast_sync_phase", os_phase, 8);
    wait_baud(64, n);
    check("fast_sync_to_baud", n, 17);

    tick();
    sync = 1'b1; tick(); sync = 1'b0;
    check("fast_sync_carry_os", os_tick, 0);
    check("fast_sync_carry_phase", os_phase, 8);
    wait_baud(64, n);
    check("fast_sync_carry_baud", n, 17);

    cfg_valid = 1'b1; cfg_inc = 32'h4000_0000; tick(); cfg_valid = 1'b0;
    k = 0;
    do begin
      wait_os(8, n);
      k++;
    end while (os_phase != 15 && k < 20);
    tick();
    sync = 1'b1; tick(); sync = 1'b0;
    check("defer_baud_suppr", baud_tick, 0);
    check("defer_os_suppr", os_tick, 0);
    check("defer_phase", os_phase, 8);
    check("defer_ready_low", cfg_ready, 0);
    wait_baud(64, n);
    check("defer_to_baud", n, 17);
    check("defer_ready_at_apply", cfg_ready, 0);
    tick();
    check("defer_ready_back", cfg_ready, 1);
    wait_baud(128, n);
    check("first_slow_bit", n + 1, 63);
    wait_baud(128, n);
    check("slow_bit", n, 64);

    cfg_valid = 1'b1; cfg_inc = 32'(INC_DEF); tick(); cfg_valid = 1'b0;
    en = 1'b0; tick();
    check("off_os_tick", os_tick, 0);
    check("off_baud_tick", baud_tick, 0);
    check("off_phase", os_phase, 0);
    check("off_ready_low", cfg_ready, 0);
    tick();
    check("off_ready_back", cfg_ready, 1);
    en = 1'b1;
    wait_os(400, n);
    check("reen_default_rate", n, 327);

    en = 1'b0; tick();
    cfg_valid = 1'b1; cfg_inc = 32'h8000_0000; tick(); cfg_valid = 1'b0;
    check("off_xfer_ready", cfg_ready, 0);
    tick(); tick();
    check("off_apply_ready", cfg_ready, 1);
    en = 1'b1;
    wait_os(8, n);
    check("reen_fast_first", n, 3);
    wait_os(8, n);
    check("reen_fast_period", n, 2);

    wait_baud(64, n);
    cfg_valid = 1'b1; cfg_inc = 32'h4000_0000; tick(); cfg_valid = 1'b0;
`endif

    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_os", os_tick, 0);
    check("async_rst_baud", baud_tick, 0);
    check("async_rst_phase", os_phase, 0);
    check("async_rst_ready", cfg_ready, READY_RST);
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    wait_os(400, n);
    check("rst_default_rate", n, 327);
    check("rst_ready_level", cfg_ready, READY_RST);
    wait_baud(6000, n);
    wait_os(400, n);
    check("rst_pending_lost", 2 * n, 651, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
